// File: rtl/flop_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : flop_div_if
//  Description : Handshake and result bundle for the flop_div half-precision
//                divider. The master side issues start/operands; the slave
//                side (the divider) returns busy/done and the unpacked
//                quotient fields.
//                Signals:
//                  start        request, sampled by the divider when idle
//                  flp_a        dividend  (sign[15], exp[14:10], frac[9:0])
//                  flp_b        divisor   (same format)
//                  busy         divider is iterating
//                  done         one-cycle result-valid pulse
//                  sign         quotient sign
//                  exponent     quotient biased exponent
//                  quot         quotient fraction, hidden bit dropped
//                  div_by_zero  last operation had flp_b == 0
//                  ovf / unf    exponent saturation flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface flop_div_if;
    logic        start;
    logic [15:0] flp_a;
    logic [15:0] flp_b;
    logic        busy;
    logic        done;
    logic        sign;
    logic [4:0]  exponent;
    logic [9:0]  quot;
    logic        div_by_zero;
    logic        ovf;
    logic        unf;

    modport master (
        output start, flp_a, flp_b,
        input  busy, done, sign, exponent, quot, div_by_zero, ovf, unf
    );

    modport slave (
        input  start, flp_a, flp_b,
        output busy, done, sign, exponent, quot, div_by_zero, ovf, unf
    );
endinterface
`default_nettype wire

// File: rtl/flop_div.sv
`default_nettype none
// ============================================================================
//  Module      : flop_div
//  Description : Sequential 16-bit half-precision divider (flp_a / flp_b).
//                The mantissa quotient comes from a restoring divider that
//                produces one quotient bit per clock (12 steps), followed by
//                a single normalisation cycle. Truncating, subnormals are
//                treated as normal, Inf/NaN are not recognised.
//                Ports:
//                  clk    rising-edge clock
//                  rst_n  asynchronous active-low reset
//                  bus    flop_div_if.slave (start/operands in,
//                         busy/done/result fields out)
//                Build option:
//                  FLOP_DIV_SAT_EN  saturate the exponent on overflow /
//                                   underflow and raise ovf / unf; when not
//                                   defined the exponent wraps and ovf / unf
//                                   stay 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module flop_div (
    input  wire logic clk,
    input  wire logic rst_n,
    flop_div_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [10:0]        r_mb,       w_mb_nxt;
    logic [11:0]        r_rem,      w_rem_nxt;
    logic [11:0]        r_q,        w_q_nxt;
    logic [3:0]         r_cnt,      w_cnt_nxt;
    logic signed [6:0]  r_ediff,    w_ediff_nxt;
    logic               r_sgn_pend, w_sgn_pend_nxt;

    logic               r_done,     w_done_nxt;
    logic               r_sign,     w_sign_nxt;
    logic [4:0]         r_exp,      w_exp_nxt;
    logic [9:0]         r_quot,     w_quot_nxt;
    logic               r_dbz,      w_dbz_nxt;
    logic               r_ovf,      w_ovf_nxt;
    logic               r_unf,      w_unf_nxt;

    // Restoring-division step helpers
    logic               w_ge;
    logic [11:0]        w_rem_sel;
    // Normalised exponent (biased, 7-bit signed so it can leave 0..31)
    logic signed [6:0]  w_e;
    logic               w_unused;

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_rem_sel = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    // A quotient without its integer bit set means ma < mb: shift one more
    // place and take one off the exponent.
    assign w_e       = r_ediff - (r_q[11] ? 7'sd0 : 7'sd1);
    // Upper exponent bits only matter to the saturating build.
    assign w_unused  = &{1'b0, w_e[6:5]};

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mb       <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_ediff    <= '0;
            r_sgn_pend <= 1'b0;
            r_done     <= 1'b0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_quot     <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mb       <= w_mb_nxt;
            r_rem      <= w_rem_nxt;
            r_q        <= w_q_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ediff    <= w_ediff_nxt;
            r_sgn_pend <= w_sgn_pend_nxt;
            r_done     <= w_done_nxt;
            r_sign     <= w_sign_nxt;
            r_exp      <= w_exp_nxt;
            r_quot     <= w_quot_nxt;
            r_dbz      <= w_dbz_nxt;
            r_ovf      <= w_ovf_nxt;
            r_unf      <= w_unf_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and result logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_mb_nxt       = r_mb;
        w_rem_nxt      = r_rem;
        w_q_nxt        = r_q;
        w_cnt_nxt      = r_cnt;
        w_ediff_nxt    = r_ediff;
        w_sgn_pend_nxt = r_sgn_pend;
        w_done_nxt     = 1'b0;
        w_sign_nxt     = r_sign;
        w_exp_nxt      = r_exp;
        w_quot_nxt     = r_quot;
        w_dbz_nxt      = r_dbz;
        w_ovf_nxt      = r_ovf;
        w_unf_nxt      = r_unf;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.flp_b == 16'h0000) begin
                        // Divisor test comes first so 0/0 also reports it.
                        w_done_nxt = 1'b1;
                        w_dbz_nxt  = 1'b1;
                        w_sign_nxt = bus.flp_a[15] ^ bus.flp_b[15];
                        w_exp_nxt  = 5'd31;
                        w_quot_nxt = '0;
                        w_ovf_nxt  = 1'b0;
                        w_unf_nxt  = 1'b0;
                    end else if (bus.flp_a == 16'h0000) begin
                        w_done_nxt = 1'b1;
                        w_dbz_nxt  = 1'b0;
                        w_sign_nxt = 1'b0;
                        w_exp_nxt  = '0;
                        w_quot_nxt = '0;
                        w_ovf_nxt  = 1'b0;
                        w_unf_nxt  = 1'b0;
                    end else begin
                        w_mb_nxt       = {1'b1, bus.flp_b[9:0]};
                        w_rem_nxt      = {1'b0, 1'b1, bus.flp_a[9:0]};
                        w_q_nxt        = '0;
                        w_cnt_nxt      = '0;
                        w_sgn_pend_nxt = bus.flp_a[15] ^ bus.flp_b[15];
                        w_ediff_nxt    = {2'b00, bus.flp_a[14:10]}
                                       - {2'b00, bus.flp_b[14:10]}
                                       + 7'sd15;
                        w_state_nxt    = CALC;
                    end
                end
            end

            CALC: begin
                // Remainder stays below 2*mb, so 12 bits always suffice.
                w_rem_nxt = w_rem_sel << 1;
                w_q_nxt   = {r_q[10:0], w_ge};
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd11) begin
                    w_state_nxt = NORM;
                end
            end

            NORM: begin
                w_done_nxt  = 1'b1;
                w_dbz_nxt   = 1'b0;
                w_sign_nxt  = r_sgn_pend;
                w_quot_nxt  = r_q[11] ? r_q[10:1] : r_q[9:0];
                w_exp_nxt   = w_e[4:0];
                w_ovf_nxt   = 1'b0;
                w_unf_nxt   = 1'b0;
`ifdef FLOP_DIV_SAT_EN
                if (w_e > 7'sd30) begin
                    w_exp_nxt  = 5'd31;
                    w_quot_nxt = '0;
                    w_ovf_nxt  = 1'b1;
                end else if (w_e < 7'sd1) begin
                    w_exp_nxt  = 5'd0;
                    w_quot_nxt = '0;
                    w_unf_nxt  = 1'b1;
                end
`endif
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.sign        = r_sign;
    assign bus.exponent    = r_exp;
    assign bus.quot        = r_quot;
    assign bus.div_by_zero = r_dbz;
    assign bus.ovf         = r_ovf;
    assign bus.unf         = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_flop_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flop_div
//  Description : Directed self-checking bench for flop_div. Expected values
//                are hand-computed half-precision quotients.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flop_div;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    flop_div_if bus ();

    flop_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a start, then wait (bounded) for done. lat is the number of
    // edges after the start edge until done is seen (99 on timeout);
    // bcnt counts sampled busy cycles before done.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int bcnt);
        bus.start = 1'b1;
        bus.flp_a = a;
        bus.flp_b = b;
        tick();
        bus.start = 1'b0;
        bcnt = bus.busy ? 1 : 0;
        lat  = 99;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic chk_res(input string tag, input logic s,
                           input logic [4:0] e, input logic [9:0] q,
                           input logic z);
        chk({tag, ".sign"},     32'(bus.sign),        32'(s));
        chk({tag, ".exponent"}, 32'(bus.exponent),    32'(e));
        chk({tag, ".quot"},     32'(bus.quot),        32'(q));
        chk({tag, ".dbz"},      32'(bus.div_by_zero), 32'(z));
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flp_a = '0;
        bus.flp_b = '0;
        tick();
        tick();

        // Reset state
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk_res("rst", 1'b0, 5'd0, 10'd0, 1'b0);
        chk("rst.ovf",  32'(bus.ovf),  32'd0);
        chk("rst.unf",  32'(bus.unf),  32'd0);
        rst_n = 1'b1;
        tick();

        // 3.0 / 1.5 = 2.0
        do_div(16'h4200, 16'h3E00, lat, bcnt);
        chk("d1.latency", 32'(lat), 32'd13);
        chk("d1.busycyc", 32'(bcnt), 32'd13);
        chk("d1.busy_at_done", 32'(bus.busy), 32'd0);
        chk_res("d1", 1'b0, 5'd16, 10'h000, 1'b0);
        chk("d1.ovf", 32'(bus.ovf), 32'd0);
        tick();
        chk("d1.done_pulse", 32'(bus.done), 32'd0);
        chk("d1.hold_exp", 32'(bus.exponent), 32'd16);

        // 1.0 / 1.5 = 0x3955
        do_div(16'h3C00, 16'h3E00, lat, bcnt);
        chk("d2.latency", 32'(lat), 32'd13);
        chk_res("d2", 1'b0, 5'd14, 10'h155, 1'b0);

        // -3.0 / 2.0 = -1.5 ... (0xC600 is -6.0): -6/2 = -3.0
        do_div(16'hC600, 16'h4000, lat, bcnt);
        chk("d3.latency", 32'(lat), 32'd13);
        chk_res("d3", 1'b1, 5'd16, 10'h200, 1'b0);

        // Divide by zero: result on the cycle after the start edge
        bus.start = 1'b1;
        bus.flp_a = 16'h4200;
        bus.flp_b = 16'h0000;
        tick();
        bus.start = 1'b0;
        chk("dz.done", 32'(bus.done), 32'd1);
        chk("dz.busy", 32'(bus.busy), 32'd0);
        chk_res("dz", 1'b0, 5'd31, 10'd0, 1'b1);
        tick();
        chk("dz.done_pulse", 32'(bus.done), 32'd0);

        // Zero dividend
        bus.start = 1'b1;
        bus.flp_a = 16'h0000;
        bus.flp_b = 16'h4200;
        tick();
        bus.start = 1'b0;
        chk("za.done", 32'(bus.done), 32'd1);
        chk("za.busy", 32'(bus.busy), 32'd0);
        chk_res("za", 1'b0, 5'd0, 10'd0, 1'b0);
        tick();

        // start pulsed mid-operation and operands changed: ignored
        bus.start = 1'b1;
        bus.flp_a = 16'h4200;
        bus.flp_b = 16'h3E00;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        bus.flp_a = 16'h3C00;
        bus.flp_b = 16'h4000;
        tick();
        bus.start = 1'b0;
        lat = 99;
        for (int i = 6; i <= 30; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("ign.latency", 32'(lat), 32'd13);
        chk_res("ign", 1'b0, 5'd16, 10'h000, 1'b0);
        tick();
        chk("ign.no_restart", 32'(bus.busy), 32'd0);

        // Reset in the middle of an operation
        bus.start = 1'b1;
        bus.flp_a = 16'h3C00;
        bus.flp_b = 16'h3E00;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("mr.busy", 32'(bus.busy), 32'd0);
        chk("mr.done", 32'(bus.done), 32'd0);
        chk_res("mr", 1'b0, 5'd0, 10'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        chk("mr.quiet", 32'(seen), 32'd0);
        do_div(16'h3C00, 16'h3E00, lat, bcnt);
        chk("mr.latency", 32'(lat), 32'd13);
        chk_res("mr.next", 1'b0, 5'd14, 10'h155, 1'b0);

        // Exponent overflow: 0x7800 / 0x0400 (biased e = 44)
        do_div(16'h7800, 16'h0400, lat, bcnt);
        chk("ov.latency", 32'(lat), 32'd13);
`ifdef FLOP_DIV_SAT_EN
        chk_res("ov", 1'b0, 5'd31, 10'd0, 1'b0);
        chk("ov.ovf", 32'(bus.ovf), 32'd1);
`else
        chk_res("ov", 1'b0, 5'd12, 10'd0, 1'b0);
        chk("ov.ovf", 32'(bus.ovf), 32'd0);
`endif
        chk("ov.unf", 32'(bus.unf), 32'd0);

        // Back-to-back: new start on the done cycle
        do_div(16'h4200, 16'h3E00, lat, bcnt);
        chk("bb1.latency", 32'(lat), 32'd13);
        chk("bb1.ovf_clear", 32'(bus.ovf), 32'd0);
        do_div(16'h3C00, 16'h3C00, lat, bcnt);
        chk("bb2.latency", 32'(lat), 32'd13);
        chk_res("bb2", 1'b0, 5'd15, 10'd0, 1'b0);
        tick();
        chk("bb2.done_pulse", 32'(bus.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flop_div.md
# flop_div

Sequential 16-bit half-precision floating-point divider: flp_a / flp_b. It is the inverse-operation companion of the team's combinational 16-bit multiplier and uses the same operand format (sign[15], exponent[14:10], fraction[9:0], bias 15) and the same unpacked result fields. The mantissa quotient is produced by a restoring divider, one quotient bit per clock, behind a start/busy/done handshake.

## Interface
Parameters: none; the format is fixed at 16 bits.
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- flp_a  input  16  dividend, captured on the start edge
- flp_b  input  16  divisor, captured on the start edge
- busy  output  1  high while in CALC or NORM
- done  output  1  one-cycle pulse; result fields valid from this cycle onward
- sign  output  1  quotient sign
- exponent  output  5  quotient biased exponent
- quot  output  10  quotient fraction, hidden bit dropped
- div_by_zero  output  1  flp_b == 0 on the last operation
- ovf  output  1  exponent overflow (FLOP_DIV_SAT_EN only; else 0)
- unf  output  1  exponent underflow (FLOP_DIV_SAT_EN only; else 0)

## Operation
- FSM states: IDLE, CALC, NORM.
- IDLE + start:
  - flp_b == 0: div_by_zero=1, sign=a[15]^b[15], exponent=31, quot=0, done=1. Stay in IDLE. Checked first, so 0/0 also flags div_by_zero.
  - else flp_a == 0 (all 16 bits): sign=0, exponent=0, quot=0, div_by_zero=0, done=1. Stay in IDLE.
  - else: load ma={1,a[9:0]}, mb={1,b[9:0]}, rem(12b)=ma, Q=0, count=0, sign=a^b. Move to CALC.
- CALC, one step per cycle, 12 steps:
  - if rem >= mb, set qbit=1 and rem -= mb; else qbit=0.
  - rem <<= 1; Q = {Q[10:0], qbit}.
  - Result: Q = floor(ma*2^11/mb). rem never exceeds 12 bits.
  - After step 12, move to NORM.
- NORM:
  - e = ea - eb + 15, computed as 7-bit signed.
  - Q[11]=1: quot=Q[10:1].
  - Q[11]=0: quot=Q[9:0] and e = e-1.
  - exponent = e[4:0] (wraps). done=1, div_by_zero=0. Return to IDLE.
- Rounding: truncation only. Subnormals are treated as normal (hidden bit forced to 1). Inf/NaN are not recognized.
- Result outputs hold their value until the next done.

## Timing
- Reset: state=IDLE; busy, done, sign, exponent, quot, div_by_zero, ovf, unf all 0. Reset mid-operation discards the operation; no done is produced.
- Normal latency: start sampled at edge 0, busy high from edge 0 to edge 13, done high in the single cycle after edge 13. Next start is accepted at edge 14 (the done cycle is IDLE).
- Special-case latency: done high in the cycle after edge 0; busy never asserts.
- start while busy is ignored. Operand changes after capture have no effect.
- done is never high for two consecutive cycles unless start is held in IDLE with special operands.

## Configuration
- FLOP_DIV_SAT_EN defined, applied in NORM:
  - e > 30: exponent=31, quot=0, ovf=1.
  - e < 1: exponent=0, quot=0, unf=1.
  - ovf and unf clear on the next done.
- Not defined: exponent=e[4:0] wraps; ovf and unf are tied to 0.

## Test plan
- 0x4200 / 0x3E00 (3.0/1.5): busy for 13 cycles, then done with sign=0, exponent=16, quot=0x000 (2.0).
- 0x3C00 / 0x3E00 (1.0/1.5): Q=0x555, exponent=14, quot=0x155 (0x3955). 0xC600 / 0x4000: sign=1, exponent=16, quot=0x200 (-3.0).
- 0x4200 / 0x0000: done the cycle after start, div_by_zero=1, exponent=31, quot=0. 0x0000 / 0x4200: done the next cycle with all fields 0.
- Pulse start at cycle 5 of an active divide: ignored, and the original result is unchanged. Drop rst_n at cycle 7 of an active divide: all outputs 0 at once, no done, and the next start works normally.
- 0x7800 / 0x0400 (e=44): with FLOP_DIV_SAT_EN, exponent=31, quot=0, ovf=1. Without it, exponent=12, quot=0, ovf=0.
- Back-to-back: start on the done cycle with 0x3C00 / 0x3C00. Accepted; done 14 cycles after the first done with exponent=15, quot=0.
